// File: rtl/axi_mem_pkg.sv
// Shared response/burst encodings and engine state types for the AXI memory responder.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address and burst legality check.
module axi_burst_addr
  import axi_mem_pkg::*;
#(
  parameter int AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [7:0]           i_len,
  input  logic [2:0]           i_size,
  input  logic [1:0]           i_burst,
  output logic [AddrWidth-1:0] o_next_addr,
  output logic                 o_illegal
);

  logic [1:0]           w_size_eff;
  logic [AddrWidth-1:0] w_step;
  logic [AddrWidth-1:0] w_incr;
  logic [AddrWidth-1:0] w_mask;
  logic                 w_wrap_len_ok;

  always_comb begin
    // Oversized beats are clamped to the bus width for address stepping.
    w_size_eff    = (i_size > 3'd3) ? 2'd3 : i_size[1:0];
    w_step        = AddrWidth'(1) << w_size_eff;
    w_incr        = i_addr + w_step;
    w_wrap_len_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    w_mask        = ((AddrWidth'(i_len) + AddrWidth'(1)) << w_size_eff) - AddrWidth'(1);
    o_illegal     = (i_size > 3'd3) || (i_burst == 2'b11) ||
                    ((i_burst == BURST_WRAP) && !w_wrap_len_ok);
    o_next_addr   = w_incr;
    if (i_burst == BURST_FIXED) begin
      o_next_addr = i_addr;
    end else if ((i_burst == BURST_WRAP) && w_wrap_len_ok) begin
      o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal word array; independent single-burst read and write engines.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int                   IdWidth   = 5,
  parameter int                   AddrWidth = 32,
  parameter int                   DataWidth = 64,
  parameter int                   MemWords  = 4096,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [IdWidth-1:0]     i_awid,
  input  logic [AddrWidth-1:0]   i_awaddr,
  input  logic [7:0]             i_awlen,
  input  logic [2:0]             i_awsize,
  input  logic [1:0]             i_awburst,
  input  logic                   i_awvalid,
  output logic                   o_awready,
  input  logic [DataWidth-1:0]   i_wdata,
  input  logic [DataWidth/8-1:0] i_wstrb,
  input  logic                   i_wlast,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  output logic [IdWidth-1:0]     o_bid,
  output logic [1:0]             o_bresp,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  input  logic [IdWidth-1:0]     i_arid,
  input  logic [AddrWidth-1:0]   i_araddr,
  input  logic [7:0]             i_arlen,
  input  logic [2:0]             i_arsize,
  input  logic [1:0]             i_arburst,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  output logic [IdWidth-1:0]     o_rid,
  output logic [DataWidth-1:0]   o_rdata,
  output logic [1:0]             o_rresp,
  output logic                   o_rlast,
  output logic                   o_rvalid,
  input  logic                   i_rready
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxWidth  = $clog2(MemWords);
  localparam int ByteOffW  = $clog2(StrbWidth);

  function automatic logic in_range(input logic [AddrWidth-1:0] a);
    return (a - BaseAddr) < AddrWidth'(MemWords * StrbWidth);
  endfunction

  function automatic logic [IdxWidth-1:0] word_idx(input logic [AddrWidth-1:0] a);
    return IdxWidth'((a - BaseAddr) >> ByteOffW);
  endfunction

  function automatic resp_e beat_resp(input logic in_rng, input logic illegal);
    return !in_rng ? RESP_DECERR : (illegal ? RESP_SLVERR : RESP_OKAY);
  endfunction

  logic [DataWidth-1:0] r_mem [MemWords];

  // ---------------- write engine ----------------
  wstate_e              r_wstate, w_wstate_next;
  logic [AddrWidth-1:0] r_waddr, w_waddr_next;
  logic [7:0]           r_awlen;
  logic [2:0]           r_awsize;
  logic [1:0]           r_awburst;
  logic [8:0]           r_wcnt;
  logic                 r_wdec, w_willegal;
  logic                 r_awready, r_wready, r_bvalid;
  logic [IdWidth-1:0]   r_bid;
  resp_e                r_bresp;
  logic                 w_aw_hs, w_w_hs, w_b_hs;

  assign w_aw_hs = i_awvalid && r_awready;
  assign w_w_hs  = i_wvalid && r_wready;
  assign w_b_hs  = r_bvalid && i_bready;

  axi_burst_addr #(.AddrWidth(AddrWidth)) u_waddr (
    .i_addr(r_waddr), .i_len(r_awlen), .i_size(r_awsize), .i_burst(r_awburst),
    .o_next_addr(w_waddr_next), .o_illegal(w_willegal)
  );

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
      W_DATA:  if (w_w_hs && i_wlast) w_wstate_next = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
      r_wdec    <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_next;
      r_awready <= (w_wstate_next == W_IDLE);
      r_wready  <= (w_wstate_next == W_DATA);
      r_bvalid  <= (w_wstate_next == W_RESP);
      if (w_aw_hs) begin
        r_bid     <= i_awid;
        r_waddr   <= i_awaddr;
        r_awlen   <= i_awlen;
        r_awsize  <= i_awsize;
        r_awburst <= i_awburst;
        r_wcnt    <= '0;
        r_wdec    <= 1'b0;
      end
      if (w_w_hs) begin
        r_waddr <= w_waddr_next;
        r_wcnt  <= r_wcnt + 9'd1;
        r_wdec  <= r_wdec || !in_range(r_waddr);
        // Decode error dominates; beat-count and burst-shape problems report SLVERR.
        if (i_wlast) begin
          if (r_wdec || !in_range(r_waddr))
            r_bresp <= RESP_DECERR;
          else if ((r_wcnt != {1'b0, r_awlen}) || w_willegal)
            r_bresp <= RESP_SLVERR;
          else
            r_bresp <= RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_w_hs && in_range(r_waddr)) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (i_wstrb[b]) r_mem[word_idx(r_waddr)][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_e              r_rstate, w_rstate_next;
  logic [AddrWidth-1:0] r_raddr, w_rnext, w_rb_addr;
  logic [7:0]           r_arlen, r_rbeat, w_rb_len;
  logic [2:0]           r_arsize, w_rb_size;
  logic [1:0]           r_arburst, w_rb_burst;
  logic                 w_rillegal;
  logic                 r_arready, r_rvalid, r_rlast;
  logic [IdWidth-1:0]   r_rid;
  logic [DataWidth-1:0] r_rdata;
  resp_e                r_rresp;
  logic                 w_ar_hs, w_r_hs;

  assign w_ar_hs = i_arvalid && r_arready;
  assign w_r_hs  = r_rvalid && i_rready;

  // Idle: check the incoming request for beat 0; busy: step the latched burst.
  assign w_rb_addr  = (r_rstate == R_IDLE) ? i_araddr  : r_raddr;
  assign w_rb_len   = (r_rstate == R_IDLE) ? i_arlen   : r_arlen;
  assign w_rb_size  = (r_rstate == R_IDLE) ? i_arsize  : r_arsize;
  assign w_rb_burst = (r_rstate == R_IDLE) ? i_arburst : r_arburst;

  axi_burst_addr #(.AddrWidth(AddrWidth)) u_raddr (
    .i_addr(w_rb_addr), .i_len(w_rb_len), .i_size(w_rb_size), .i_burst(w_rb_burst),
    .o_next_addr(w_rnext), .o_illegal(w_rillegal)
  );

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rbeat   <= '0;
    end else begin
      r_rstate  <= w_rstate_next;
      r_arready <= (w_rstate_next == R_IDLE);
      r_rvalid  <= (w_rstate_next == R_DATA);
      if (w_ar_hs) begin
        r_rid     <= i_arid;
        r_raddr   <= i_araddr;
        r_arlen   <= i_arlen;
        r_arsize  <= i_arsize;
        r_arburst <= i_arburst;
        r_rbeat   <= '0;
        r_rlast   <= (i_arlen == 8'd0);
        r_rdata   <= in_range(i_araddr) ? r_mem[word_idx(i_araddr)] : '0;
        r_rresp   <= beat_resp(in_range(i_araddr), w_rillegal);
      end else if (w_r_hs && !r_rlast) begin
        r_raddr   <= w_rnext;
        r_rbeat   <= r_rbeat + 8'd1;
        r_rlast   <= ((r_rbeat + 8'd1) == r_arlen);
        r_rdata   <= in_range(w_rnext) ? r_mem[word_idx(w_rnext)] : '0;
        r_rresp   <= beat_resp(in_range(w_rnext), w_rillegal);
      end
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bid     = r_bid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rlast   = r_rlast;
  assign o_rid     = r_rid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed, table-driven bench for axi_mem_responder with hand-written corner-case sequences.
module tb_axi_mem_responder;

  localparam int TMO = 50;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  i_awid = '0;
  logic [31:0] i_awaddr = '0;
  logic [7:0]  i_awlen = '0;
  logic [2:0]  i_awsize = '0;
  logic [1:0]  i_awburst = '0;
  logic        i_awvalid = 1'b0;
  logic        o_awready;
  logic [63:0] i_wdata = '0;
  logic [7:0]  i_wstrb = '0;
  logic        i_wlast = 1'b0;
  logic        i_wvalid = 1'b0;
  logic        o_wready;
  logic [4:0]  o_bid;
  logic [1:0]  o_bresp;
  logic        o_bvalid;
  logic        i_bready = 1'b0;
  logic [4:0]  i_arid = '0;
  logic [31:0] i_araddr = '0;
  logic [7:0]  i_arlen = '0;
  logic [2:0]  i_arsize = '0;
  logic [1:0]  i_arburst = '0;
  logic        i_arvalid = 1'b0;
  logic        o_arready;
  logic [4:0]  o_rid;
  logic [63:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rlast;
  logic        o_rvalid;
  logic        i_rready = 1'b0;

  always #5 clk_i = ~clk_i;

  axi_mem_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
    .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  typedef struct {
    bit          wr;
    logic [4:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  strb;
    logic [63:0] d[4];
    logic [1:0]  resp[4];
    int          last_beat;
    bit          chkd;
  } vec_t;

  vec_t vt[21];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                          input logic [63:0] d[4], input int last_beat, input bit bp,
                          output logic [1:0] bresp, output logic [4:0] bid);
    int t;
    bit hs;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    t = 0;
    do begin hs = o_awready; @(negedge clk_i); t++; end while (!hs && t < TMO);
    if (!hs) chk("aw_timeout", 0, 1);
    i_awvalid = 1'b0;
    for (int b = 0; b <= last_beat; b++) begin
      i_wdata = d[b % 4]; i_wstrb = strb; i_wlast = (b == last_beat); i_wvalid = 1'b1;
      t = 0;
      do begin hs = o_wready; @(negedge clk_i); t++; end while (!hs && t < TMO);
      if (!hs) chk("w_timeout", 0, 1);
      i_wvalid = 1'b0; i_wlast = 1'b0;
    end
    t = 0;
    while (!o_bvalid && t < TMO) begin @(negedge clk_i); t++; end
    chk("b_valid", o_bvalid, 1);
    bresp = o_bresp; bid = o_bid;
    if (bp) begin
      repeat ($urandom_range(1, 5)) begin
        @(negedge clk_i);
        chk("b_hold_valid", o_bvalid, 1);
        chk("b_hold_resp", o_bresp, bresp);
        chk("b_hold_id", o_bid, bid);
      end
    end
    i_bready = 1'b1;
    @(negedge clk_i);
    i_bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit bp,
                         input logic [63:0] ed[4], input logic [1:0] er[4], input bit chkd);
    int t;
    bit hs;
    logic [63:0] cd;
    logic [1:0]  cr;
    logic        cl;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    i_arvalid = 1'b1;
    t = 0;
    do begin hs = o_arready; @(negedge clk_i); t++; end while (!hs && t < TMO);
    if (!hs) chk("ar_timeout", 0, 1);
    i_arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (!o_rvalid && t < TMO) begin @(negedge clk_i); t++; end
      if (!o_rvalid) begin chk("r_timeout", 0, 1); return; end
      if (!bp) chk("r_gap", 64'(t), 0);
      cd = o_rdata; cr = o_rresp; cl = o_rlast;
      if (bp) begin
        repeat ($urandom_range(1, 5)) begin
          @(negedge clk_i);
          chk("r_hold", {o_rvalid, o_rlast, o_rresp, o_rdata}, {1'b1, cl, cr, cd});
        end
      end
      if (chkd) chk("rdata", o_rdata, ed[b % 4]);
      chk("rresp", o_rresp, er[b % 4]);
      chk("rlast", o_rlast, (b == int'(len)));
      chk("rid", o_rid, id);
      i_rready = 1'b1;
      @(negedge clk_i);
      i_rready = 1'b0;
    end
    chk("r_done", o_rvalid, 0);
  endtask

  initial begin
    logic [1:0]  br;
    logic [4:0]  bi;
    logic [63:0] dz[4];
    logic [1:0]  rz[4];
    int          t;

    vt[0]  = '{1'b1, 5'd5,  32'h100,  8'd3, 3'd3, 2'd1, 8'hFF, '{64'h11, 64'h22, 64'h33, 64'h44}, '{2'd0, 2'd0, 2'd0, 2'd0}, 3, 1'b1};
    vt[1]  = '{1'b0, 5'd7,  32'h100,  8'd3, 3'd3, 2'd1, 8'h00, '{64'h11, 64'h22, 64'h33, 64'h44}, '{2'd0, 2'd0, 2'd0, 2'd0}, 3, 1'b1};
    vt[2]  = '{1'b0, 5'd3,  32'h118,  8'd3, 3'd3, 2'd2, 8'h00, '{64'h44, 64'h11, 64'h22, 64'h33}, '{2'd0, 2'd0, 2'd0, 2'd0}, 3, 1'b1};
    vt[3]  = '{1'b0, 5'd1,  32'h100,  8'd2, 3'd3, 2'd2, 8'h00, '{64'h0, 64'h0, 64'h0, 64'h0},     '{2'd2, 2'd2, 2'd2, 2'd2}, 2, 1'b0};
    vt[4]  = '{1'b1, 5'd2,  32'h200,  8'd0, 3'd3, 2'd1, 8'hFF, '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[5]  = '{1'b1, 5'd2,  32'h200,  8'd0, 3'd3, 2'd1, 8'h0F, '{64'h0, 64'h0, 64'h0, 64'h0},     '{2'd0, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[6]  = '{1'b0, 5'd4,  32'h200,  8'd0, 3'd3, 2'd1, 8'h00, '{64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0, 64'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[7]  = '{1'b1, 5'd6,  32'h0,    8'd0, 3'd3, 2'd1, 8'hFF, '{64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[8]  = '{1'b1, 5'd6,  32'h8000, 8'd0, 3'd3, 2'd1, 8'hFF, '{64'hDEAD, 64'h0, 64'h0, 64'h0},  '{2'd3, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[9]  = '{1'b0, 5'd6,  32'h0,    8'd0, 3'd3, 2'd1, 8'h00, '{64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[10] = '{1'b1, 5'd9,  32'h7FF8, 8'd0, 3'd3, 2'd1, 8'hFF, '{64'hCAFE, 64'h0, 64'h0, 64'h0},  '{2'd0, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[11] = '{1'b0, 5'd10, 32'h7FF8, 8'd1, 3'd3, 2'd1, 8'h00, '{64'hCAFE, 64'h0, 64'h0, 64'h0},  '{2'd0, 2'd3, 2'd0, 2'd0}, 1, 1'b1};
    vt[12] = '{1'b1, 5'd11, 32'h300,  8'd1, 3'd3, 2'd0, 8'hFF, '{64'hAAAA, 64'hBBBB, 64'h0, 64'h0}, '{2'd0, 2'd0, 2'd0, 2'd0}, 1, 1'b1};
    vt[13] = '{1'b0, 5'd12, 32'h300,  8'd0, 3'd3, 2'd1, 8'h00, '{64'hBBBB, 64'h0, 64'h0, 64'h0},  '{2'd0, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[14] = '{1'b1, 5'd13, 32'h308,  8'd0, 3'd4, 2'd1, 8'hFF, '{64'h5A5A, 64'h0, 64'h0, 64'h0},  '{2'd2, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[15] = '{1'b1, 5'd14, 32'h310,  8'd0, 3'd3, 2'd3, 8'hFF, '{64'h6B6B, 64'h0, 64'h0, 64'h0},  '{2'd2, 2'd0, 2'd0, 2'd0}, 0, 1'b1};
    vt[16] = '{1'b1, 5'd15, 32'h400,  8'd3, 3'd3, 2'd1, 8'hFF, '{64'h1, 64'h2, 64'h0, 64'h0},     '{2'd2, 2'd0, 2'd0, 2'd0}, 1, 1'b1};
    vt[17] = '{1'b1, 5'd16, 32'h408,  8'd1, 3'd3, 2'd2, 8'hFF, '{64'h5, 64'h6, 64'h0, 64'h0},     '{2'd0, 2'd0, 2'd0, 2'd0}, 1, 1'b1};
    vt[18] = '{1'b0, 5'd17, 32'h400,  8'd1, 3'd3, 2'd1, 8'h00, '{64'h6, 64'h5, 64'h0, 64'h0},     '{2'd0, 2'd0, 2'd0, 2'd0}, 1, 1'b1};
    vt[19] = '{1'b0, 5'd18, 32'h308,  8'd0, 3'd4, 2'd1, 8'h00, '{64'h0, 64'h0, 64'h0, 64'h0},     '{2'd2, 2'd0, 2'd0, 2'd0}, 0, 1'b0};
    vt[20] = '{1'b0, 5'd31, 32'h7FF8, 8'd0, 3'd3, 2'd3, 8'h00, '{64'h0, 64'h0, 64'h0, 64'h0},     '{2'd2, 2'd0, 2'd0, 2'd0}, 0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {o_awready, o_arready, o_wready}, 3'b000);
    chk("rst_valid", {o_bvalid, o_rvalid, o_rlast}, 3'b000);
    chk("rst_ids_resp", {o_bid, o_rid, o_bresp, o_rresp}, 14'h0);
    chk("rst_rdata", o_rdata, 64'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", {o_awready, o_arready}, 2'b11);
    i_wvalid = 1'b1;
    @(negedge clk_i);
    chk("w_held_off", o_wready, 0);
    i_wvalid = 1'b0;

    for (int v = 0; v < 21; v++) begin
      if (vt[v].wr) begin
        do_write(vt[v].id, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst, vt[v].strb,
                 vt[v].d, vt[v].last_beat, 1'b0, br, bi);
        chk("bresp", br, vt[v].resp[0]);
        chk("bid", bi, vt[v].id);
        $display("vec %0d write addr=%h len=%0d bresp=%0d", v, vt[v].addr, vt[v].len, br);
      end else begin
        do_read(vt[v].id, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst, 1'b0,
                vt[v].d, vt[v].resp, vt[v].chkd);
        $display("vec %0d read  addr=%h len=%0d", v, vt[v].addr, vt[v].len);
      end
    end

    // Backpressure on R and B
    do_read(5'd20, 32'h100, 8'd3, 3'd3, 2'd1, 1'b1, vt[1].d, vt[1].resp, 1'b1);
    $display("seq bp read addr=00000100 len=3");
    dz = '{64'h77, 64'h88, 64'h0, 64'h0};
    rz = '{2'd0, 2'd0, 2'd0, 2'd0};
    do_write(5'd21, 32'h208, 8'd1, 3'd3, 2'd1, 8'hFF, dz, 1, 1'b1, br, bi);
    chk("bp_bresp", br, 2'd0);
    do_read(5'd22, 32'h208, 8'd1, 3'd3, 2'd1, 1'b1, dz, rz, 1'b1);
    $display("seq bp write/read addr=00000208 bresp=%0d", br);

    // Same-word read and write in the same cycle
    dz = '{64'hA0A0, 64'h0, 64'h0, 64'h0};
    do_write(5'd1, 32'h500, 8'd0, 3'd3, 2'd1, 8'hFF, dz, 0, 1'b0, br, bi);
    i_awid = 5'd2; i_awaddr = 32'h500; i_awlen = 8'd0; i_awsize = 3'd3; i_awburst = 2'd1;
    i_awvalid = 1'b1;
    t = 0;
    while (!o_awready && t < TMO) begin @(negedge clk_i); t++; end
    @(negedge clk_i);
    i_awvalid = 1'b0;
    chk("coll_wready", o_wready, 1);
    chk("coll_arready", o_arready, 1);
    i_wdata = 64'hB1B1; i_wstrb = 8'hFF; i_wlast = 1'b1; i_wvalid = 1'b1;
    i_arid = 5'd3; i_araddr = 32'h500; i_arlen = 8'd0; i_arsize = 3'd3; i_arburst = 2'd1;
    i_arvalid = 1'b1;
    @(negedge clk_i);
    i_wvalid = 1'b0; i_wlast = 1'b0; i_arvalid = 1'b0;
    chk("coll_rvalid", o_rvalid, 1);
    chk("coll_old_data", o_rdata, 64'hA0A0);
    chk("coll_bvalid", o_bvalid, 1);
    i_rready = 1'b1; i_bready = 1'b1;
    @(negedge clk_i);
    i_rready = 1'b0; i_bready = 1'b0;
    dz = '{64'hB1B1, 64'h0, 64'h0, 64'h0};
    do_read(5'd4, 32'h500, 8'd0, 3'd3, 2'd1, 1'b0, dz, rz, 1'b1);
    $display("seq collide addr=00000500");

    // Reset in the middle of a read burst
    i_arid = 5'd9; i_araddr = 32'h100; i_arlen = 8'd3; i_arsize = 3'd3; i_arburst = 2'd1;
    i_arvalid = 1'b1;
    t = 0;
    while (!o_arready && t < TMO) begin @(negedge clk_i); t++; end
    @(negedge clk_i);
    i_arvalid = 1'b0;
    chk("mid_beat0", {o_rvalid, o_rdata}, {1'b1, 64'h11});
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_rvalid", o_rvalid, 0);
    chk("mid_rst_arready", o_arready, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rel_arready", o_arready, 1);
    chk("rel_rvalid", o_rvalid, 0);
    do_read(5'd10, 32'h100, 8'd3, 3'd3, 2'd1, 1'b0, vt[1].d, vt[1].resp, 1'b1);
    $display("seq reset mid-read, memory retained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave that terminates the interconnect's memory-side master port (5-bit IDs, 32-bit address, 64-bit data) and backs it with an internal word-addressed storage array. Used as the simulation/FPGA memory behind the icache/dcache crossbar. Independent read and write engines each handle one burst at a time, with full FIXED/INCR/WRAP burst support and AXI error responses.

## Interface
- IdWidth, 5, AXI ID width; matches crossbar master-side ID width (4 + 1).
- AddrWidth, 32, AXI address width.
- DataWidth, 64, AXI data width; strobe width DataWidth/8.
- MemWords, 4096, storage depth in DataWidth words (32 KiB).
- BaseAddr, 32'h0000_0000, byte address of word 0.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- i_awid/i_awaddr/i_awlen/i_awsize/i_awburst  in  IdWidth/AddrWidth/8/3/2  write address.
- i_awvalid  in  1;  o_awready  out  1.
- i_wdata/i_wstrb/i_wlast/i_wvalid  in  DataWidth/DataWidth/8/1/1;  o_wready  out  1.
- o_bid/o_bresp/o_bvalid  out  IdWidth/2/1;  i_bready  in  1.
- i_arid/i_araddr/i_arlen/i_arsize/i_arburst  in  IdWidth/AddrWidth/8/3/2  read address.
- i_arvalid  in  1;  o_arready  out  1.
- o_rid/o_rdata/o_rresp/o_rlast/o_rvalid  out  IdWidth/DataWidth/2/1/1;  i_rready  in  1.
- AxLOCK/CACHE/PROT/REGION/QOS and atop not ported; ignored.

## Operation
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch id/addr/len/size/burst, W_DATA (wready=1) -> each W handshake writes bytes where wstrb=1 to word (addr-BaseAddr)>>3, advance addr, beat count++ -> W handshake with wlast -> W_RESP (bvalid=1, bid=latched id) -> on bready -> W_IDLE.
- bresp: DECERR(2'b11) if any beat out of range (write suppressed for that beat); else SLVERR(2'b10) if wlast beat count != awlen+1, size>3, burst=2'b11, or illegal WRAP len; else OKAY.
- Read FSM: R_IDLE (arready=1) -> on AR handshake latch fields, load rdata with beat 0, R_DATA (rvalid=1) -> each R handshake loads next beat into output registers -> handshake with rlast -> R_IDLE.
- rresp per beat: DECERR if beat out of range (rdata=0); else SLVERR for size>3, burst=2'b11, illegal WRAP len; else OKAY. rlast on beat awlen-equivalent arlen.
- Address advance: FIXED unchanged; INCR addr+(1<<size); WRAP len in {1,3,7,15}, mask=((len+1)<<size)-1, next=(addr&~mask)|((addr+(1<<size))&mask). size>3 advances by 8; burst 2'b11 treated as INCR. 32-bit INCR wraps modulo 2^32.
- In range: addr-BaseAddr < MemWords*8 (unsigned). Low 3 address bits ignored for word select.
- Read/write same word same cycle: read returns old data; write visible to fetches from next cycle.
- Storage not reset.

## Timing
- Reset values: awready=arready=wready=bvalid=rvalid=rlast=0, bid=rid=0, bresp=rresp=0, rdata=0; FSMs in IDLE. awready/arready rise the first cycle after rst_i deasserts.
- All outputs registered; no combinational valid->ready paths.
- Write: AW accepted cycle 0; wready from cycle 1; W before AW acceptance is held off (legal). bvalid cycle after wlast handshake; held with stable bid/bresp until bready; awready the cycle after B handshake.
- Read: AR accepted cycle 0; rvalid with beat 0 cycle 1; one beat per cycle while rready=1; rvalid/rdata stable while rready=0. arready the cycle after last handshake (one-cycle bubble between bursts).
- Reset mid-burst: both FSMs abort to IDLE, pending B/R dropped; partially written words keep written data.

## Structure
- Package axi_mem_pkg: resp codes (OKAY/SLVERR/DECERR), burst codes (FIXED/INCR/WRAP), FSM state enums.
- Sub-module axi_burst_addr (combinational next-address + legality flag from addr/len/size/burst), instantiated once per engine.

## Test plan
- INCR write len=3 size=3 at 0x100, data 0x11..0x44, strb 0xFF -> bresp OKAY bid echoed; INCR read same -> 4 beats 0x11..0x44, rlast on beat 3, one beat/cycle with rready=1.
- WRAP read len=3 size=3 at 0x118 -> beat addresses 0x118,0x100,0x108,0x110; len=2 WRAP -> rresp SLVERR all beats.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF then wstrb=0x0F data 0 at 0x200 -> read returns 0xFFFF_FFFF_0000_0000.
- Out of range: write to 0x8000 (MemWords=4096) -> bresp DECERR, memory unchanged; read 0x7FF8 len=1 -> beat0 OKAY, beat1 DECERR rdata 0.
- Backpressure: random rready/bready low for 1–5 cycles -> rdata/rresp/rlast/bresp stable, no beat lost or duplicated; wlast early (len=3, wlast on beat 1) -> SLVERR.
- Concurrent read+write to same word, and rst_i asserted mid-read burst -> rvalid=0 next cycle, arready=1 cycle after release.
